// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end sharing one saturating 16-bit add/sub unit.
// Define ADDSUB_ARB_SAT_CNT_EN to add the o_sat_cnt saturation event counter.
module addsub_arbiter #(
   parameter int CNT_W = 8
) (
`ifdef ADDSUB_ARB_SAT_CNT_EN
   output logic [CNT_W-1:0] o_sat_cnt,
`endif
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req0_vld,
   input  logic [15:0] i_req0_a,
   input  logic [15:0] i_req0_b,
   input  logic        i_req0_sub,
   output logic        o_req0_rdy,
   output logic        o_rsp0_vld,
   input  logic        i_rsp0_rdy,
   output logic [15:0] o_rsp0_sum,
   output logic        o_rsp0_ovf,
   input  logic        i_req1_vld,
   input  logic [15:0] i_req1_a,
   input  logic [15:0] i_req1_b,
   input  logic        i_req1_sub,
   output logic        o_req1_rdy,
   output logic        o_rsp1_vld,
   input  logic        i_rsp1_rdy,
   output logic [15:0] o_rsp1_sum,
   output logic        o_rsp1_ovf
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]  r_state;
   logic        r_last;
   logic        r_owner;
   logic [15:0] r_a;
   logic [15:0] r_b;
   logic        r_sub;
   logic [15:0] r_sum;
   logic        r_ovf;

   logic        w_gnt;
   logic        w_idle;
   logic        w_resp;
   logic        w_hs;
   logic        w_rsp_rdy;
   logic [15:0] w_b_eff;
   logic [15:0] w_raw;
   logic        w_pos_ovf;
   logic        w_neg_ovf;
   logic [15:0] w_sat_sum;

   // Contention goes to whoever did not win last; a lone requester always wins.
   assign w_gnt  = (i_req0_vld & i_req1_vld) ? ~r_last : i_req1_vld;
   assign w_idle = (r_state == S_IDLE) & ~i_rst;
   assign w_resp = (r_state == S_RESP);

   assign o_req0_rdy = w_idle & i_req0_vld & ~w_gnt;
   assign o_req1_rdy = w_idle & i_req1_vld &  w_gnt;
   assign w_hs       = o_req0_rdy | o_req1_rdy;
   assign w_rsp_rdy  = r_owner ? i_rsp1_rdy : i_rsp0_rdy;

   // a - b computed as a + ~b + 1; overflow only when both addends share a sign.
   assign w_b_eff   = r_b ^ {16{r_sub}};
   assign w_raw     = r_a + w_b_eff + {15'd0, r_sub};
   assign w_pos_ovf = ~r_a[15] & ~w_b_eff[15] &  w_raw[15];
   assign w_neg_ovf =  r_a[15] &  w_b_eff[15] & ~w_raw[15];
   assign w_sat_sum = w_pos_ovf ? 16'h7FFF : (w_neg_ovf ? 16'h8000 : w_raw);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_last  <= 1'b1;
         r_owner <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_sub   <= 1'b0;
         r_sum   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_hs) begin
                  r_a     <= w_gnt ? i_req1_a   : i_req0_a;
                  r_b     <= w_gnt ? i_req1_b   : i_req0_b;
                  r_sub   <= w_gnt ? i_req1_sub : i_req0_sub;
                  r_owner <= w_gnt;
                  r_last  <= w_gnt;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_sum   <= w_sat_sum;
               r_ovf   <= w_pos_ovf | w_neg_ovf;
               r_state <= S_RESP;
            end
            S_RESP: begin
               if (w_rsp_rdy) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef ADDSUB_ARB_SAT_CNT_EN
   logic [CNT_W-1:0] r_sat_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sat_cnt <= '0;
      end else if ((r_state == S_EXEC) && (w_pos_ovf | w_neg_ovf) && (r_sat_cnt != '1)) begin
         r_sat_cnt <= r_sat_cnt + 1'b1;
      end
   end

   assign o_sat_cnt = r_sat_cnt;
`endif

   assign o_rsp0_vld = w_resp & ~r_owner;
   assign o_rsp1_vld = w_resp &  r_owner;
   assign o_rsp0_sum = o_rsp0_vld ? r_sum : 16'h0000;
   assign o_rsp1_sum = o_rsp1_vld ? r_sum : 16'h0000;
   assign o_rsp0_ovf = o_rsp0_vld & r_ovf;
   assign o_rsp1_ovf = o_rsp1_vld & r_ovf;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Scoreboard bench for addsub_arbiter: arbitration order, latency, saturation, back-pressure, reset abort.
module tb_addsub_arbiter;

   typedef struct {
      logic        owner;
      logic [15:0] sum;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_vld, req0_sub, req0_rdy, rsp0_vld, rsp0_rdy, rsp0_ovf;
   logic [15:0] req0_a, req0_b, rsp0_sum;
   logic        req1_vld, req1_sub, req1_rdy, rsp1_vld, rsp1_rdy, rsp1_ovf;
   logic [15:0] req1_a, req1_b, rsp1_sum;
`ifdef ADDSUB_ARB_SAT_CNT_EN
   logic [7:0]  sat_cnt;
`endif

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   n_ovf = 0;
   logic last  = 1'b1;

   always #5 clk = ~clk;

   addsub_arbiter #(.CNT_W(8)) dut (
`ifdef ADDSUB_ARB_SAT_CNT_EN
      .o_sat_cnt  (sat_cnt),
`endif
      .i_clk      (clk),
      .i_rst      (rst),
      .i_req0_vld (req0_vld),
      .i_req0_a   (req0_a),
      .i_req0_b   (req0_b),
      .i_req0_sub (req0_sub),
      .o_req0_rdy (req0_rdy),
      .o_rsp0_vld (rsp0_vld),
      .i_rsp0_rdy (rsp0_rdy),
      .o_rsp0_sum (rsp0_sum),
      .o_rsp0_ovf (rsp0_ovf),
      .i_req1_vld (req1_vld),
      .i_req1_a   (req1_a),
      .i_req1_b   (req1_b),
      .i_req1_sub (req1_sub),
      .o_req1_rdy (req1_rdy),
      .o_rsp1_vld (rsp1_vld),
      .i_rsp1_rdy (rsp1_rdy),
      .o_rsp1_sum (rsp1_sum),
      .o_rsp1_ovf (rsp1_ovf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference arithmetic in plain integers, clamped to the 16-bit signed range.
   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic sub);
      exp_t e;
      int   r;
      r = sub ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
      e.owner = 1'b0;
      if (r > 32767)       begin e.sum = 16'h7FFF; e.ovf = 1'b1; end
      else if (r < -32768) begin e.sum = 16'h8000; e.ovf = 1'b1; end
      else                 begin e.sum = r[15:0];  e.ovf = 1'b0; end
      return e;
   endfunction

   task automatic chk_idle_outs(input string tag);
      chk({tag, "_rdy"}, {30'd0, req0_rdy, req1_rdy}, 32'd0);
      chk({tag, "_vld"}, {30'd0, rsp0_vld, rsp1_vld}, 32'd0);
      chk({tag, "_sum"}, {rsp0_sum, rsp1_sum}, 32'd0);
      chk({tag, "_ovf"}, {30'd0, rsp0_ovf, rsp1_ovf}, 32'd0);
   endtask

   // Drives a request cycle, checks the grant, then checks the EXEC cycle.
   task automatic issue(input logic v0, input logic [15:0] a0, input logic [15:0] b0, input logic s0,
                        input logic v1, input logic [15:0] a1, input logic [15:0] b1, input logic s1);
      int   g;
      exp_t e;
      @(negedge clk);
      req0_vld = v0; req0_a = a0; req0_b = b0; req0_sub = s0;
      req1_vld = v1; req1_a = a1; req1_b = b1; req1_sub = s1;
      #1;
      g = (v0 && v1) ? (last ? 0 : 1) : (v1 ? 1 : 0);
      chk("grant_rdy0", {31'd0, req0_rdy}, {31'd0, g == 0});
      chk("grant_rdy1", {31'd0, req1_rdy}, {31'd0, g == 1});
      e = (g == 1) ? model(a1, b1, s1) : model(a0, b0, s0);
      e.owner = (g == 1);
      sb.push_back(e);
      last = (g == 1);
      @(negedge clk);
      #1;
      chk("exec_rdy", {30'd0, req0_rdy, req1_rdy}, 32'd0);
      chk("exec_vld", {30'd0, rsp0_vld, rsp1_vld}, 32'd0);
      req0_vld = 1'b0; req1_vld = 1'b0;
   endtask

   // Expects the response in the very next cycle (handshake + 2), optionally stalls it.
   task automatic collect(input int hold);
      exp_t e;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      @(negedge clk);
      #1;
      chk("rsp_vld0", {31'd0, rsp0_vld}, {31'd0, !e.owner});
      chk("rsp_vld1", {31'd0, rsp1_vld}, {31'd0, e.owner});
      chk("rsp_sum", {16'd0, e.owner ? rsp1_sum : rsp0_sum}, {16'd0, e.sum});
      chk("rsp_ovf", {31'd0, e.owner ? rsp1_ovf : rsp0_ovf}, {31'd0, e.ovf});
      chk("rsp_other_zero", {16'd0, e.owner ? rsp0_sum : rsp1_sum}, 32'd0);
      if (e.ovf) n_ovf++;
      if (hold > 0) begin
         req0_vld = 1'b1; req1_vld = 1'b1;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            chk("hold_vld", {30'd0, rsp1_vld, rsp0_vld}, e.owner ? 32'd2 : 32'd1);
            chk("hold_sum", {16'd0, e.owner ? rsp1_sum : rsp0_sum}, {16'd0, e.sum});
            chk("hold_rdy", {30'd0, req0_rdy, req1_rdy}, 32'd0);
         end
         req0_vld = 1'b0; req1_vld = 1'b0;
      end
      if (e.owner) rsp1_rdy = 1'b1; else rsp0_rdy = 1'b1;
      @(negedge clk);
      rsp0_rdy = 1'b0; rsp1_rdy = 1'b0;
      #1;
      chk("post_rsp_vld", {30'd0, rsp0_vld, rsp1_vld}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      req0_vld = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0; rsp0_rdy = 1'b0;
      req1_vld = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0; rsp1_rdy = 1'b0;
      repeat (3) @(negedge clk);
      req0_vld = 1'b1; req1_vld = 1'b1;
      #1;
      chk_idle_outs("reset");
`ifdef ADDSUB_ARB_SAT_CNT_EN
      chk("reset_sat_cnt", {24'd0, sat_cnt}, 32'd0);
`endif
      req0_vld = 1'b0; req1_vld = 1'b0;
      rst = 1'b0;

      // Round-robin: contention after reset goes 0, 1, 0.
      issue(1, 16'h0005, 16'h0003, 0, 1, 16'h0100, 16'h0001, 1); collect(0);
      issue(1, 16'h1234, 16'h1111, 1, 1, 16'hFFFF, 16'hFFFF, 0); collect(0);
      issue(1, 16'h4000, 16'h4000, 0, 1, 16'h0002, 16'h0003, 1); collect(0);

      issue(1, 16'h0005, 16'h0003, 0, 0, 16'h0000, 16'h0000, 0); collect(0);
      issue(0, 16'h0000, 16'h0000, 0, 1, 16'h7FFF, 16'h0001, 0); collect(0);
      issue(0, 16'h0000, 16'h0000, 0, 1, 16'h8000, 16'h0001, 1); collect(0);
      issue(1, 16'h0000, 16'h8000, 1, 0, 16'h0000, 16'h0000, 0); collect(0);
      issue(1, 16'hFFFF, 16'h8000, 1, 0, 16'h0000, 16'h0000, 0); collect(0);

      // Back-pressure: response held 5 cycles while both requesters wait.
      issue(1, 16'h00A0, 16'h0B00, 1, 0, 16'h0000, 16'h0000, 0); collect(5);

      // Operands changed after the handshake must not leak into the result.
      issue(1, 16'h0010, 16'h0001, 0, 0, 16'h0000, 16'h0000, 0);
      req0_a = 16'h7000;
      collect(0);

      // Reset during EXEC aborts the operation.
      issue(0, 16'h0000, 16'h0000, 0, 1, 16'h7FFF, 16'h7FFF, 0);
      rst = 1'b1;
      void'(sb.pop_back());
      @(negedge clk);
      rst = 1'b0;
      last = 1'b1;
      #1;
      chk_idle_outs("abort");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         chk("abort_no_rsp", {30'd0, rsp0_vld, rsp1_vld}, 32'd0);
      end
`ifdef ADDSUB_ARB_SAT_CNT_EN
      n_ovf = 0;
`endif
      issue(1, 16'h0005, 16'h0003, 0, 1, 16'h0001, 16'h0001, 0); collect(0);

      for (int i = 0; i < 10; i++) begin
         logic v0, v1;
         v0 = 1'($urandom_range(0, 1));
         v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
         issue(v0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
               v1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
         collect(i % 3);
      end

`ifdef ADDSUB_ARB_SAT_CNT_EN
      chk("sat_cnt", {24'd0, sat_cnt}, n_ovf);
`endif
      chk("sb_drained", sb.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 Parameter: CNT_W, 8, width of saturation event counter.
REQ-002 clk  in  1  rising-edge clock, single domain.
REQ-003 rst  in  1  synchronous reset, active-high.
REQ-004 req0_vld  in  1  requester 0 operation request.
REQ-005 req0_a, req0_b  in  16  requester 0 signed operands.
REQ-006 req0_sub  in  1  requester 0 op: 0 = a+b, 1 = a-b.
REQ-007 req0_rdy  out  1  request accepted this cycle when high with req0_vld.
REQ-008 rsp0_vld  out  1  requester 0 result valid.
REQ-009 rsp0_rdy  in  1  requester 0 consumes result.
REQ-010 rsp0_sum  out  16  saturated signed result.
REQ-011 rsp0_ovf  out  1  result saturated.
REQ-012 req1_*/rsp1_*: identical port set for requester 1.
REQ-013 sat_cnt  out  CNT_W  saturation event count (present only per REQ-032).

Function
REQ-014 Block owns one saturating 16-bit add/sub datapath shared by two requesters; one operation in flight at a time.
REQ-015 FSM states IDLE, EXEC, RESP; reset state IDLE.
REQ-016 IDLE: reqN_rdy = 1 only for granted requester when any reqN_vld high; on handshake operands, op and owner ID register, next state EXEC.
REQ-017 EXEC (one cycle): datapath evaluates registered operands; sum, ovf and owner register; next state RESP.
REQ-018 RESP: rspN_vld = 1 for owner only; sum/ovf held stable; on rspN_rdy = 1 next state IDLE; otherwise remain in RESP.
REQ-019 Latency: request handshake cycle N -> rspN_vld high cycle N+2; minimum issue interval 3 cycles.
REQ-020 No reqN_rdy asserted in EXEC or RESP.
REQ-021 Arbitration round-robin: last-grant pointer resets to 1 so requester 0 wins first simultaneous request; pointer updates only on request handshake.
REQ-022 Single requester valid: granted regardless of pointer.
REQ-023 Arithmetic: subtraction = a + ~b + 1; result saturates to 16'h7FFF on positive overflow, 16'h8000 on negative overflow; ovf = 1 exactly when saturated; carry-out discarded.
REQ-024 Operands/op captured at handshake; input changes afterward do not affect the result.
REQ-025 Deasserting reqN_vld without handshake is permitted; no state change.
REQ-026 rspN_sum/rspN_ovf drive 0 when rspN_vld = 0.

Reset
REQ-027 rst high at clk edge: state IDLE, pointer 1, all rdy/vld outputs 0, sum/ovf 0, sat_cnt 0.
REQ-028 Reset in EXEC or RESP aborts the operation; no response is ever issued for it.
REQ-029 Output values hold reset values during the cycle following rst deassertion until a new handshake.

Configuration
REQ-030 Macro ADDSUB_ARB_SAT_CNT_EN controls saturation statistics.
REQ-031 Defined: sat_cnt port exists; increments by 1 in each EXEC cycle producing ovf = 1; saturates at all-ones (no wrap).
REQ-032 Undefined: sat_cnt port and counter logic absent; all other behaviour identical.

Verification
REQ-033 req0 only, a=16'h0005, b=16'h0003, sub=0 -> rsp0_vld at N+2, sum 16'h0008, ovf 0.
REQ-034 req0 and req1 valid same cycle after reset -> req0 granted first; second arbitration grants req1; third with both valid grants req0.
REQ-035 req1 a=16'h7FFF, b=16'h0001, sub=0 -> sum 16'h7FFF, ovf 1; a=16'h8000, b=16'h0001, sub=1 -> sum 16'h8000, ovf 1; sat_cnt = 2 with macro.
REQ-036 rsp0_rdy held low 5 cycles -> FSM stays RESP, rsp0_sum stable, req1_rdy low throughout; rdy high -> IDLE next cycle.
REQ-037 rst asserted during EXEC -> no rspN_vld ever for that operation; all outputs 0 next cycle; subsequent request completes normally.
REQ-038 Change req0_a after handshake from 16'h0010 to 16'h7000 -> result uses 16'h0010.
